// File: rtl/axi_bridge_ip_tx_beat_arbiter.sv
// Frame-granular round-robin arbiter that shares one TX segment generator
// between NUM_CH beat sources and holds each grant until the frame completes.
module axi_bridge_ip_tx_beat_arbiter #(
   parameter int NUM_CH  = 4,
   parameter int DATA_W  = 256,
   parameter int IF_W    = 64,
   parameter int TUSER_W = 16,
   localparam int NSEG_W =
      $clog2((DATA_W/8 + IF_W/8 - 1) / (IF_W/8) + 1),
   localparam int LSB_W  = $clog2(DATA_W/8 + 1),
   localparam int CH_W   = $clog2(NUM_CH)
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        enable_i,
   input  logic                        flush_i,
   input  logic [NUM_CH-1:0]           ch_mask_i,
   input  logic [NUM_CH-1:0]           ch_valid_i,
   input  logic [NUM_CH*DATA_W-1:0]    ch_data_i,
   input  logic [NUM_CH*DATA_W/8-1:0]  ch_keep_i,
   input  logic [NUM_CH*TUSER_W-1:0]   ch_user_i,
   input  logic [NUM_CH-1:0]           ch_last_i,
   input  logic [NUM_CH*NSEG_W-1:0]    ch_num_segs_i,
   input  logic [NUM_CH*LSB_W-1:0]     ch_last_seg_bytes_i,
   output logic [NUM_CH-1:0]           ch_ready_o,
   output logic                        beat_valid_o,
   output logic [DATA_W-1:0]           beat_data_o,
   output logic [DATA_W/8-1:0]         beat_keep_o,
   output logic [TUSER_W-1:0]          beat_user_o,
   output logic                        beat_last_o,
   output logic [NSEG_W-1:0]           beat_num_segs_o,
   output logic [LSB_W-1:0]            beat_last_seg_bytes_o,
   input  logic                        beat_ready_i,
   input  logic                        frame_done_pulse_i,
   output logic                        grant_valid_o,
   output logic [CH_W-1:0]             grant_ch_o,
   output logic [31:0]                 frames_done_cnt_o,
   output logic                        proto_err_o
);

   localparam int KEEP_W = DATA_W / 8;

   typedef enum logic [1:0] {
      S_IDLE,
      S_GRANT,
      S_DRAIN
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CH_W-1:0]   r_grant_ch;
   logic [CH_W-1:0]   w_grant_nxt;
   logic [CH_W-1:0]   r_ptr;
   logic [CH_W-1:0]   w_ptr_nxt;
   logic [31:0]       r_cnt;
   logic              r_err;

   logic              w_live;
   logic [NUM_CH-1:0] w_req;
   logic              w_found;
   logic [CH_W-1:0]   w_pick;
   logic [CH_W:0]     w_dist;
   logic [CH_W:0]     w_best;
   logic              w_acc;
   logic              w_last;
   logic              w_zero_seg;
   logic              w_done;
   logic              w_err_set;

   assign w_live = enable_i & ~flush_i;
   assign w_req  = ch_valid_i & ch_mask_i;

   // Closest requester at or above the pointer, measured with wrap.
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      w_best  = '0;
      w_dist  = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         w_dist = (CH_W+1)'(c)
                + ((CH_W'(c) >= r_ptr) ? '0 : (CH_W+1)'(NUM_CH))
                - {1'b0, r_ptr};
         if (w_req[c] && (!w_found || w_dist < w_best)) begin
            w_found = 1'b1;
            w_best  = w_dist;
            w_pick  = CH_W'(c);
         end
      end
   end

   assign beat_data_o = ch_data_i[r_grant_ch*DATA_W +: DATA_W];
   assign beat_keep_o = ch_keep_i[r_grant_ch*KEEP_W +: KEEP_W];
   assign beat_user_o = ch_user_i[r_grant_ch*TUSER_W +: TUSER_W];
   assign beat_last_o = ch_last_i[r_grant_ch];
   assign beat_num_segs_o =
      ch_num_segs_i[r_grant_ch*NSEG_W +: NSEG_W];
   assign beat_last_seg_bytes_o =
      ch_last_seg_bytes_i[r_grant_ch*LSB_W +: LSB_W];

   assign w_last     = ch_last_i[r_grant_ch];
   assign w_zero_seg = (beat_num_segs_o == '0);
   assign w_acc      = (r_state == S_GRANT) & w_live
                     & beat_ready_i & ch_valid_i[r_grant_ch];

   always_comb begin
      ch_ready_o   = '0;
      beat_valid_o = 1'b0;
      if (r_state == S_GRANT && w_live) begin
         beat_valid_o           = ch_valid_i[r_grant_ch];
         ch_ready_o[r_grant_ch] = beat_ready_i;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant_ch;
      w_ptr_nxt   = r_ptr;
      w_done      = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_live && w_found) begin
               w_state_nxt = S_GRANT;
               w_grant_nxt = w_pick;
            end
         end
         S_GRANT: begin
            if (flush_i)
               w_state_nxt = S_IDLE;
            else if (w_acc && w_last)
               w_state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            // Completion is honoured even while paused.
            if (flush_i) begin
               w_state_nxt = S_IDLE;
            end else if (frame_done_pulse_i) begin
               w_state_nxt = S_IDLE;
               w_done      = 1'b1;
               w_ptr_nxt   = (r_grant_ch == CH_W'(NUM_CH-1))
                           ? '0 : r_grant_ch + 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_err_set = (frame_done_pulse_i && r_state != S_DRAIN)
                    | (w_acc & w_zero_seg);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= S_IDLE;
         r_grant_ch <= '0;
         r_ptr      <= '0;
         r_cnt      <= '0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_grant_ch <= w_grant_nxt;
         r_ptr      <= w_ptr_nxt;
         if (w_done)
            r_cnt <= r_cnt + 32'd1;
         if (w_err_set)
            r_err <= 1'b1;
      end
   end

   assign grant_valid_o     = (r_state != S_IDLE);
   assign grant_ch_o        = r_grant_ch;
   assign frames_done_cnt_o = r_cnt;
   assign proto_err_o       = r_err;

endmodule

// File: tb/tb_axi_bridge_ip_tx_beat_arbiter.sv
// Directed scenarios plus randomized traffic checked against a
// frame-level reference model of the TX beat arbiter.
module tb_axi_bridge_ip_tx_beat_arbiter;

   localparam int NUM_CH  = 4;
   localparam int DATA_W  = 256;
   localparam int IF_W    = 64;
   localparam int TUSER_W = 16;
   localparam int KEEP_W  = DATA_W / 8;
   localparam int NSEG_W  = 3;
   localparam int LSB_W   = 6;
   localparam int CH_W    = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, en, fl, bready, fd;
   logic [NUM_CH-1:0] mask, valid, last;
   logic [DATA_W-1:0]  d  [NUM_CH];
   logic [KEEP_W-1:0]  k  [NUM_CH];
   logic [TUSER_W-1:0] u  [NUM_CH];
   logic [NSEG_W-1:0]  ns [NUM_CH];
   logic [LSB_W-1:0]   lb [NUM_CH];

   logic [NUM_CH*DATA_W-1:0]  bus_d;
   logic [NUM_CH*KEEP_W-1:0]  bus_k;
   logic [NUM_CH*TUSER_W-1:0] bus_u;
   logic [NUM_CH*NSEG_W-1:0]  bus_ns;
   logic [NUM_CH*LSB_W-1:0]   bus_lb;

   logic [NUM_CH-1:0]  rdy;
   logic               bv, blast, gv, err;
   logic [DATA_W-1:0]  bdata;
   logic [KEEP_W-1:0]  bkeep;
   logic [TUSER_W-1:0] buser;
   logic [NSEG_W-1:0]  bns;
   logic [LSB_W-1:0]   blb;
   logic [CH_W-1:0]    gch;
   logic [31:0]        cnt;

   int n_cmp = 0;
   int n_bad = 0;

   always_comb begin
      bus_d  = '0;
      bus_k  = '0;
      bus_u  = '0;
      bus_ns = '0;
      bus_lb = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         bus_d[c*DATA_W +: DATA_W]    = d[c];
         bus_k[c*KEEP_W +: KEEP_W]    = k[c];
         bus_u[c*TUSER_W +: TUSER_W]  = u[c];
         bus_ns[c*NSEG_W +: NSEG_W]   = ns[c];
         bus_lb[c*LSB_W +: LSB_W]     = lb[c];
      end
   end

   axi_bridge_ip_tx_beat_arbiter #(
      .NUM_CH(NUM_CH), .DATA_W(DATA_W),
      .IF_W(IF_W), .TUSER_W(TUSER_W)
   ) dut (
      .clk_i                 (clk),
      .rst_ni                (rst_n),
      .enable_i              (en),
      .flush_i               (fl),
      .ch_mask_i             (mask),
      .ch_valid_i            (valid),
      .ch_data_i             (bus_d),
      .ch_keep_i             (bus_k),
      .ch_user_i             (bus_u),
      .ch_last_i             (last),
      .ch_num_segs_i         (bus_ns),
      .ch_last_seg_bytes_i   (bus_lb),
      .ch_ready_o            (rdy),
      .beat_valid_o          (bv),
      .beat_data_o           (bdata),
      .beat_keep_o           (bkeep),
      .beat_user_o           (buser),
      .beat_last_o           (blast),
      .beat_num_segs_o       (bns),
      .beat_last_seg_bytes_o (blb),
      .beat_ready_i          (bready),
      .frame_done_pulse_i    (fd),
      .grant_valid_o         (gv),
      .grant_ch_o            (gch),
      .frames_done_cnt_o     (cnt),
      .proto_err_o           (err)
   );

   function automatic logic [DATA_W-1:0] rnd_data();
      logic [DATA_W-1:0] r;
      for (int i = 0; i < DATA_W/32; i++)
         r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic clear_in();
      en = 1'b1; fl = 1'b0; bready = 1'b0; fd = 1'b0;
      mask = '1; valid = '0; last = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         d[c] = '0; k[c] = '0; u[c] = '0;
         ns[c] = 3'd1; lb[c] = 6'd8;
      end
   endtask

   task automatic do_reset();
      clear_in();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      clear_in();
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      #1;
      n_cmp++;
      if ({gv, gch, cnt, err, rdy, bv} !== '0) begin
         n_bad++;
         $display("FAIL reset_vals: gv=%b gch=%0d cnt=%0d err=%b rdy=%b bv=%b, required all 0",
                  gv, gch, cnt, err, rdy, bv);
      end
      rst_n = 1'b1;
      valid[0] = 1'b1;
      bready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      #1;
      n_cmp++;
      if (rdy !== 4'b0001) begin
         n_bad++;
         $display("FAIL reset_grant_ready: rdy=%b, required 0001", rdy);
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({rdy, bv, gv} !== '0) begin
         n_bad++;
         $display("FAIL async_rst_grant: rdy=%b bv=%b gv=%b, required 0",
                  rdy, bv, gv);
      end
   endtask

   task automatic test_single();
      do_reset();
      valid[1] = 1'b1;
      ns[1] = 3'd2;
      bready = 1'b1;
      #1;
      n_cmp++;
      if (gv !== 1'b0) begin
         n_bad++;
         $display("FAIL single_idle: gv=%b, required 0", gv);
      end
      @(posedge clk);
      for (int b = 0; b < 3; b++) begin
         @(negedge clk);
         last[1] = (b == 2);
         d[1] = rnd_data();
         #1;
         n_cmp++;
         if ({gv, gch, rdy} !== {1'b1, 2'd1, 4'b0010}) begin
            n_bad++;
            $display("FAIL single_beat%0d: gv=%b gch=%0d rdy=%b, required 1 1 0010",
                     b, gv, gch, rdy);
         end
         n_cmp++;
         if ({bdata, blast} !== {d[1], last[1]}) begin
            n_bad++;
            $display("FAIL single_data%0d: last=%b, required %b (data %0s)",
                     b, blast, last[1], (bdata === d[1]) ? "ok" : "wrong");
         end
         @(posedge clk);
      end
      @(negedge clk);
      valid = '0;
      last = '0;
      #1;
      n_cmp++;
      if ({gv, rdy, bv} !== {1'b1, 4'b0000, 1'b0}) begin
         n_bad++;
         $display("FAIL single_drain: gv=%b rdy=%b bv=%b, required 1 0000 0",
                  gv, rdy, bv);
      end
      fd = 1'b1;
      @(posedge clk);
      @(negedge clk);
      fd = 1'b0;
      #1;
      n_cmp++;
      if ({gv, cnt} !== {1'b0, 32'd1}) begin
         n_bad++;
         $display("FAIL single_done: gv=%b cnt=%0d, required 0 1", gv, cnt);
      end
      valid = 4'b0110;
      @(posedge clk);
      @(negedge clk);
      #1;
      n_cmp++;
      if ({gv, gch, err} !== {1'b1, 2'd2, 1'b0}) begin
         n_bad++;
         $display("FAIL single_ptr: gv=%b gch=%0d err=%b, required 1 2 0",
                  gv, gch, err);
      end
   endtask

   task automatic test_round_robin();
      int order [5] = '{0, 1, 2, 3, 0};
      do_reset();
      valid = '1;
      last = '1;
      bready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         @(negedge clk);
         #1;
         n_cmp++;
         if ({gch, rdy} !== {CH_W'(order[i]), 4'(1 << order[i])}) begin
            n_bad++;
            $display("FAIL rr_grant%0d: gch=%0d rdy=%b, required %0d",
                     i, gch, rdy, order[i]);
         end
         @(posedge clk);
         @(negedge clk);
         fd = 1'b1;
         #1;
         n_cmp++;
         if ({gv, bv, gch} !== {1'b1, 1'b0, CH_W'(order[i])}) begin
            n_bad++;
            $display("FAIL rr_hold%0d: gv=%b bv=%b gch=%0d, required 1 0 %0d",
                     i, gv, bv, gch, order[i]);
         end
         @(posedge clk);
         @(negedge clk);
         fd = 1'b0;
         #1;
         n_cmp++;
         if ({gv, cnt} !== {1'b0, 32'(i + 1)}) begin
            n_bad++;
            $display("FAIL rr_release%0d: gv=%b cnt=%0d, required 0 %0d",
                     i, gv, cnt, i + 1);
         end
      end
   endtask

   task automatic test_mask();
      int order [4] = '{3, 0, 1, 3};
      do_reset();
      valid = 4'b0100;
      bready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      #1;
      n_cmp++;
      if ({gch, rdy} !== {2'd2, 4'b0100}) begin
         n_bad++;
         $display("FAIL mask_grant: gch=%0d rdy=%b, required 2 0100", gch, rdy);
      end
      mask = 4'b1011;
      valid = '1;
      #1;
      n_cmp++;
      if (rdy !== 4'b0100) begin
         n_bad++;
         $display("FAIL mask_keep: rdy=%b, required 0100", rdy);
      end
      @(posedge clk);
      @(negedge clk);
      last = '1;
      @(posedge clk);
      @(negedge clk);
      fd = 1'b1;
      @(posedge clk);
      @(negedge clk);
      fd = 1'b0;
      #1;
      n_cmp++;
      if ({gv, cnt} !== {1'b0, 32'd1}) begin
         n_bad++;
         $display("FAIL mask_done: gv=%b cnt=%0d, required 0 1", gv, cnt);
      end
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         @(negedge clk);
         #1;
         n_cmp++;
         if ({gv, gch} !== {1'b1, CH_W'(order[i])}) begin
            n_bad++;
            $display("FAIL mask_order%0d: gv=%b gch=%0d, required 1 %0d",
                     i, gv, gch, order[i]);
         end
         @(posedge clk);
         @(negedge clk);
         fd = 1'b1;
         @(posedge clk);
         @(negedge clk);
         fd = 1'b0;
      end
   endtask

   task automatic test_backpressure();
      logic [DATA_W-1:0] dexp;
      do_reset();
      valid = 4'b0001;
      last = 4'b0001;
      d[0] = rnd_data();
      dexp = d[0];
      @(posedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         n_cmp++;
         if ({bv, rdy} !== {1'b1, 4'b0000} || bdata !== dexp) begin
            n_bad++;
            $display("FAIL bp_stall%0d: bv=%b rdy=%b data_ok=%b, required 1 0000 1",
                     i, bv, rdy, bdata === dexp);
         end
         @(posedge clk);
      end
      @(negedge clk);
      bready = 1'b1;
      #1;
      n_cmp++;
      if (rdy !== 4'b0001 || bdata !== dexp) begin
         n_bad++;
         $display("FAIL bp_accept: rdy=%b data_ok=%b, required 0001 1",
                  rdy, bdata === dexp);
      end
      @(posedge clk);
      @(negedge clk);
      #1;
      n_cmp++;
      if ({gv, bv} !== 2'b10) begin
         n_bad++;
         $display("FAIL bp_drain: gv=%b bv=%b, required 1 0", gv, bv);
      end
   endtask

   task automatic test_flush();
      do_reset();
      valid = 4'b0010;
      last = 4'b0010;
      bready = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      fd = 1'b1;
      @(posedge clk);
      @(negedge clk);
      fd = 1'b0;
      valid = 4'b1000;
      last = '0;
      @(posedge clk);
      @(negedge clk);
      #1;
      n_cmp++;
      if ({gch, rdy} !== {2'd3, 4'b1000}) begin
         n_bad++;
         $display("FAIL flush_grant3: gch=%0d rdy=%b, required 3 1000", gch, rdy);
      end
      @(posedge clk);
      @(negedge clk);
      fl = 1'b1;
      #1;
      n_cmp++;
      if ({rdy, bv} !== 5'b0) begin
         n_bad++;
         $display("FAIL flush_no_acc: rdy=%b bv=%b, required 0", rdy, bv);
      end
      @(posedge clk);
      @(negedge clk);
      fl = 1'b0;
      valid = '1;
      #1;
      n_cmp++;
      if ({gv, cnt} !== {1'b0, 32'd1}) begin
         n_bad++;
         $display("FAIL flush_idle: gv=%b cnt=%0d, required 0 1", gv, cnt);
      end
      @(posedge clk);
      @(negedge clk);
      #1;
      n_cmp++;
      if ({gv, gch} !== {1'b1, 2'd2}) begin
         n_bad++;
         $display("FAIL flush_ptr: gv=%b gch=%0d, required 1 2", gv, gch);
      end
   endtask

   task automatic test_proto_err();
      do_reset();
      fd = 1'b1;
      @(posedge clk);
      @(negedge clk);
      fd = 1'b0;
      #1;
      n_cmp++;
      if (err !== 1'b1) begin
         n_bad++;
         $display("FAIL err_idle_done: err=%b, required 1", err);
      end
      valid = 4'b0001;
      last = 4'b0001;
      bready = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      valid = '0;
      #1;
      n_cmp++;
      if ({err, gv, bv} !== 3'b110) begin
         n_bad++;
         $display("FAIL err_sticky_drain: err=%b gv=%b bv=%b, required 1 1 0",
                  err, gv, bv);
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({gv, gch, cnt, err, rdy, bv} !== '0) begin
         n_bad++;
         $display("FAIL async_rst_drain: gv=%b cnt=%0d err=%b rdy=%b bv=%b, required 0",
                  gv, cnt, err, rdy, bv);
      end
      do_reset();
      valid = 4'b0001;
      ns[0] = 3'd0;
      bready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      #1;
      n_cmp++;
      if (err !== 1'b0) begin
         n_bad++;
         $display("FAIL zseg_pre: err=%b, required 0", err);
      end
      @(posedge clk);
      @(negedge clk);
      #1;
      n_cmp++;
      if (err !== 1'b1) begin
         n_bad++;
         $display("FAIL zseg_err: err=%b, required 1", err);
      end
   endtask

   task automatic test_random();
      int m_owner = -1;
      bit m_drain = 0;
      int m_ptr = 0;
      int m_gch = 0;
      int m_cnt = 0;
      bit m_err = 0;
      logic [NUM_CH-1:0] e_rdy;
      bit e_bv;
      do_reset();
      for (int cyc = 0; cyc < 800; cyc++) begin
         en     = ($urandom_range(0, 99) < 85);
         fl     = ($urandom_range(0, 99) < 3);
         bready = ($urandom_range(0, 99) < 70);
         if (cyc % 25 == 0)
            mask = NUM_CH'($urandom);
         valid = NUM_CH'($urandom);
         for (int c = 0; c < NUM_CH; c++) begin
            last[c] = ($urandom_range(0, 99) < 30);
            d[c]  = rnd_data();
            k[c]  = $urandom;
            u[c]  = TUSER_W'($urandom);
            ns[c] = NSEG_W'($urandom_range(1, 4));
            lb[c] = LSB_W'($urandom_range(1, 32));
         end
         fd = (m_owner >= 0 && m_drain) && ($urandom_range(0, 99) < 35);
         #1;
         e_bv  = 0;
         e_rdy = '0;
         if (m_owner >= 0 && !m_drain && en && !fl) begin
            e_bv = valid[m_owner];
            e_rdy[m_owner] = bready;
         end
         n_cmp++;
         if ({gv, gch, bv, rdy} !== {m_owner >= 0, CH_W'(m_gch), e_bv, e_rdy}) begin
            n_bad++;
            $display("FAIL rnd_ctrl@%0d: gv=%b gch=%0d bv=%b rdy=%b, required %b %0d %b %b",
                     cyc, gv, gch, bv, rdy, m_owner >= 0, m_gch, e_bv, e_rdy);
         end
         n_cmp++;
         if ({cnt, err} !== {32'(m_cnt), m_err}) begin
            n_bad++;
            $display("FAIL rnd_stat@%0d: cnt=%0d err=%b, required %0d %b",
                     cyc, cnt, err, m_cnt, m_err);
         end
         if (e_bv) begin
            n_cmp++;
            if ({bdata, bkeep, buser, blast, bns, blb} !==
                {d[m_owner], k[m_owner], u[m_owner], last[m_owner],
                 ns[m_owner], lb[m_owner]}) begin
               n_bad++;
               $display("FAIL rnd_beat@%0d: last=%b segs=%0d lsb=%0d, required %b %0d %0d from ch %0d",
                        cyc, blast, bns, blb, last[m_owner], ns[m_owner],
                        lb[m_owner], m_owner);
            end
         end
         if (fd && !(m_owner >= 0 && m_drain))
            m_err = 1;
         if (fl) begin
            m_owner = -1;
            m_drain = 0;
         end else if (m_owner < 0) begin
            if (en) begin
               for (int s = 0; s < NUM_CH; s++) begin
                  int c = (m_ptr + s) % NUM_CH;
                  if (valid[c] && mask[c]) begin
                     m_owner = c;
                     m_gch = c;
                     break;
                  end
               end
            end
         end else if (!m_drain) begin
            if (en && bready && valid[m_owner]) begin
               if (ns[m_owner] == 0)
                  m_err = 1;
               if (last[m_owner])
                  m_drain = 1;
            end
         end else if (fd) begin
            m_ptr = (m_owner + 1) % NUM_CH;
            m_owner = -1;
            m_drain = 0;
            m_cnt++;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      rst_n = 1'b1;
      clear_in();
      test_reset();
      test_single();
      test_round_robin();
      test_mask();
      test_backpressure();
      test_flush();
      test_proto_err();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: run did not reach its end, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/axi_bridge_ip_tx_beat_arbiter.md
Name: axi_bridge_ip_tx_beat_arbiter

Overview:
- Frame-granular round-robin arbiter sharing one TX segment generator between NUM_CH beat sources (per-channel beat_fetch instances).
- Holds a grant for a whole frame and forwards that channel's beats to the segment generator's beat interface.
- Releases the grant only after the segment generator reports frame completion.
- Exposes the grant owner and frame statistics to control/status logic.

Parameters:
- NUM_CH, 4, number of requesting channels (>=2).
- DATA_W, 256, beat data width in bits.
- IF_W, 64, segment width in bits; sizes NSEG_W.
- TUSER_W, 16, user sideband width.
- Derived: NSEG_W = $clog2(ceil((DATA_W/8)/(IF_W/8))+1); LSB_W = $clog2(DATA_W/8+1); CH_W = $clog2(NUM_CH).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- enable_i  in  1  arbiter enable; low = pause.
- flush_i  in  1  synchronous flush; drops grant.
- ch_mask_i  in  NUM_CH  1 = channel eligible for new grants.
- ch_valid_i  in  NUM_CH  per-channel beat valid.
- ch_data_i  in  NUM_CH*DATA_W  beat data, channel c at [c*DATA_W +: DATA_W].
- ch_keep_i  in  NUM_CH*DATA_W/8  beat keep.
- ch_user_i  in  NUM_CH*TUSER_W  beat user.
- ch_last_i  in  NUM_CH  last beat of frame.
- ch_num_segs_i  in  NUM_CH*NSEG_W  segments in beat.
- ch_last_seg_bytes_i  in  NUM_CH*LSB_W  bytes in last segment.
- ch_ready_o  out  NUM_CH  per-channel beat accept.
- beat_valid_o, beat_data_o, beat_keep_o, beat_user_o, beat_last_o, beat_num_segs_o, beat_last_seg_bytes_o  out  (matching widths)  muxed beat to the segment generator.
- beat_ready_i  in  1  segment generator ready.
- frame_done_pulse_i  in  1  segment generator frame-completion pulse.
- grant_valid_o  out  1  a channel holds the grant.
- grant_ch_o  out  CH_W  granted channel index.
- frames_done_cnt_o  out  32  completed frames, wraps at 2^32.
- proto_err_o  out  1  sticky protocol error.

Behaviour:
- Reset values:
  - state = IDLE; grant_valid_o = 0; grant_ch_o = 0.
  - RR pointer = 0; frames_done_cnt_o = 0; proto_err_o = 0.
  - ch_ready_o = 0; beat_valid_o = 0.
- States: IDLE, GRANT, DRAIN.
- IDLE:
  - req = ch_valid_i & ch_mask_i.
  - If enable_i && !flush_i && req != 0, select the first set bit searching from the RR pointer upward, with wrap.
  - Register the grant; move to GRANT next cycle. Arbitration latency is 1 cycle.
- GRANT:
  - Outputs are a combinational mux of granted channel g.
  - beat_valid_o = enable_i && !flush_i && ch_valid_i[g].
  - ch_ready_o[g] = enable_i && !flush_i && beat_ready_i; all other ch_ready_o bits = 0.
  - Accept = ch_valid_i[g] && ch_ready_o[g].
  - Accept with ch_last_i[g] = 1 moves to DRAIN.
- DRAIN:
  - beat_valid_o = 0; ch_ready_o = 0.
  - On frame_done_pulse_i: move to IDLE; grant_valid_o drops; RR pointer = (g+1) mod NUM_CH; frames_done_cnt_o increments by 1.
- grant_valid_o = 1 in GRANT and DRAIN; grant_ch_o holds g until the next grant.
- ch_mask_i affects only new arbitration. A granted channel keeps its grant when masked mid-frame.
- enable_i low: state, grant and pointer are held; no accepts occur; frame_done_pulse_i in DRAIN is still honoured.
- flush_i (priority over all other events):
  - Next state = IDLE; grant cleared; RR pointer unchanged.
  - No accept in the flush cycle; frames_done_cnt_o not incremented.
- proto_err_o sets (and stays set until reset) when frame_done_pulse_i = 1 in IDLE or GRANT, or when an accepted beat has ch_num_segs_i = 0.
- Only one frame is outstanding in the segment generator; a new grant is not issued in the same cycle DRAIN exits.
- Reset mid-frame: asynchronous return to reset values; ch_ready_o drops immediately.

Test Plan:
- Single channel 1, 3-beat frame, beat_ready_i = 1:
  - grant_ch_o = 1 one cycle after ch_valid_i[1].
  - 3 consecutive ch_ready_o[1] pulses; DRAIN after the last beat.
  - frame_done_pulse_i -> IDLE, frames_done_cnt_o = 1, pointer = 2.
- All 4 channels requesting continuously with 1-beat frames: grant order 0,1,2,3,0; each grant lasts until its frame_done_pulse_i.
- Channel 2 mid-frame with ch_mask_i[2] dropped: frame completes on channel 2, then channel 2 receives no further grant while the other channels are served.
- Backpressure with beat_ready_i = 0 for 5 cycles in GRANT: beat_valid_o = 1, ch_ready_o = 0, data stable; beat accepted the cycle beat_ready_i returns.
- flush_i during GRANT of channel 3 after 1 of 4 beats: next cycle IDLE, grant_valid_o = 0, pointer unchanged, counter unchanged.
- frame_done_pulse_i injected in IDLE: proto_err_o = 1 and remains set until reset; asynchronous reset mid-DRAIN clears all outputs immediately.
